// File: rtl/ste_pulse_gen_if.sv
// Control/status bundle for ste_pulse_gen: trigger and duration inputs,
// pulse output and queue/overflow status.
interface ste_pulse_gen_if #(
    parameter int CNT_W  = 4,
    parameter int PEND_W = 3
);
    logic              trig_i;
    logic [CNT_W-1:0]  len_high_i;
    logic [CNT_W-1:0]  len_low_i;
    logic              clr_ovf_i;
    logic              dout_o;
    logic              busy_o;
    logic [PEND_W-1:0] pend_o;
    logic              ovf_o;

    modport master (
        output trig_i, len_high_i, len_low_i, clr_ovf_i,
        input  dout_o, busy_o, pend_o, ovf_o
    );

    modport slave (
        input  trig_i, len_high_i, len_low_i, clr_ovf_i,
        output dout_o, busy_o, pend_o, ovf_o
    );
endinterface

// File: rtl/ste_pulse_gen.sv
// Edge-triggered pulse generator with programmable high time and minimum low time.
// Define STE_PULSE_GEN_QUEUE_EN to queue triggers that arrive while a pulse is running.
module ste_pulse_gen #(
    parameter int CNT_W  = 4,
    parameter int PEND_W = 3
) (
    input  logic clk,
    input  logic reset_ni,
    ste_pulse_gen_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_dout;
    logic              w_dout_next;
    logic              r_trig_q;
    logic              r_ovf;
    logic              w_ovf_next;
    logic              w_ovf_set;
    logic              w_edge;
    logic              w_cnt_zero;
    logic              w_at_boundary;
    logic              w_start;
    logic              w_take;

    assign w_edge        = bus.trig_i & ~r_trig_q;
    assign w_cnt_zero    = (r_cnt == '0);
    // A new pulse may only begin from idle or once the low time has run out.
    assign w_at_boundary = (r_state == S_IDLE) | ((r_state == S_LOW) & w_cnt_zero);

`ifdef STE_PULSE_GEN_QUEUE_EN
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_next;
    logic              w_pend_nz;
    logic              w_inc;
    logic              w_dec;

    assign w_pend_nz = (r_pend != '0);
    assign w_start   = w_pend_nz | w_edge;
    assign w_take    = w_at_boundary & w_start;
    assign w_dec     = w_take & w_pend_nz;
    // An edge bypasses the queue only when it starts a pulse with the queue empty.
    assign w_inc     = w_edge & ~(w_take & ~w_pend_nz);

    always_comb begin
        w_pend_next = r_pend;
        w_ovf_set   = 1'b0;
        if (w_inc && !w_dec) begin
            if (r_pend == '1) begin
                w_ovf_set = 1'b1;
            end else begin
                w_pend_next = r_pend + PEND_W'(1);
            end
        end else if (w_dec && !w_inc) begin
            w_pend_next = r_pend - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign bus.pend_o = r_pend;
`else
    assign w_start    = w_edge & w_at_boundary;
    assign w_take     = w_start;
    assign w_ovf_set  = w_edge & ~w_take;
    assign bus.pend_o = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_dout_next  = r_dout;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_cnt_next   = bus.len_high_i;
                    w_dout_next  = 1'b1;
                    w_state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_cnt_zero) begin
                    w_cnt_next   = bus.len_low_i;
                    w_dout_next  = 1'b0;
                    w_state_next = S_LOW;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (!w_cnt_zero) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else if (w_take) begin
                    w_cnt_next   = bus.len_high_i;
                    w_dout_next  = 1'b1;
                    w_state_next = S_HIGH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_dout_next  = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Set has priority over clear so a lost trigger is never hidden.
    assign w_ovf_next = w_ovf_set ? 1'b1 : (bus.clr_ovf_i ? 1'b0 : r_ovf);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dout   <= 1'b0;
            r_trig_q <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_dout   <= w_dout_next;
            r_trig_q <= bus.trig_i;
            r_ovf    <= w_ovf_next;
        end
    end

    assign bus.dout_o = r_dout;
    assign bus.busy_o = (r_state != S_IDLE);
    assign bus.ovf_o  = r_ovf;
endmodule

// File: tb/tb_ste_pulse_gen.sv
// Directed bench for ste_pulse_gen: table of per-cycle vectors plus
// hand-written queue, overflow and reset sequences.
module tb_ste_pulse_gen;
    localparam int CNT_W  = 4;
    localparam int PEND_W = 3;
`ifdef STE_PULSE_GEN_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct {
        logic       trig;
        logic [3:0] lh;
        logic [3:0] ll;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    logic clk;
    logic reset_ni;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    ste_pulse_gen_if #(.CNT_W(CNT_W), .PEND_W(PEND_W)) bus ();

    ste_pulse_gen #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] pk(input logic d, input logic b,
                                      input logic [2:0] p, input logic o);
        return {d, b, p, o};
    endfunction

    function automatic logic [5:0] act();
        return {bus.dout_o, bus.busy_o, bus.pend_o, bus.ovf_o};
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, a, e);
        end else begin
            $display("ok   %s[%0d]: %h", name, idx, a);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic [3:0] lh,
                         input logic [3:0] ll, input logic c);
        bus.trig_i     = t;
        bus.len_high_i = lh;
        bus.len_low_i  = ll;
        bus.clr_ovf_i  = c;
    endtask

    task automatic add(input logic t, input logic [3:0] lh, input logic [3:0] ll,
                       input logic c, input logic d, input logic b,
                       input logic [2:0] p, input logic o);
        vec_t v;
        v.trig = t; v.lh = lh; v.ll = ll; v.clr = c;
        v.exp  = pk(d, b, p, o);
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        reset_ni = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_ni = 1'b0;
        drive(1'b0, 4'd2, 4'd1, 1'b0);

        // basic pulse: high 3, low 2
        add(0, 2, 1, 0,  0, 0, 0, 0);
        add(1, 2, 1, 0,  1, 1, 0, 0);
        add(1, 2, 1, 0,  1, 1, 0, 0);
        add(0, 2, 1, 0,  1, 1, 0, 0);
        add(0, 2, 1, 0,  0, 1, 0, 0);
        add(0, 2, 1, 0,  0, 1, 0, 0);
        add(0, 2, 1, 0,  0, 0, 0, 0);
        // zero lengths, trigger toggling every cycle
        add(1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 0);
        add(1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 0);
        add(1, 0, 0, 0,  1, 1, 0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0);
        // len_high 7 -> 1 mid-pulse: 8 high cycles, then a 2-cycle pulse
        add(1, 7, 0, 0,  1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 0, 0,  0, 1, 0, 0);
        add(1, 1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 0, 0,  1, 1, 0, 0);
        add(0, 1, 0, 0,  0, 1, 0, 0);
        add(0, 1, 0, 0,  0, 0, 0, 0);

        tick();
        tick();
        chk("reset_hold", 0, 32'(act()), 32'(pk(0, 0, 0, 0)));
        reset_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].trig, vecs[i].lh, vecs[i].ll, vecs[i].clr);
            tick();
            chk("vec", i, 32'(act()), 32'(vecs[i].exp));
        end

`ifdef STE_PULSE_GEN_QUEUE_EN
        // three edges during a 6-cycle pulse -> four pulses, 1-cycle gaps
        for (int c = 1; c <= 29; c++) begin
            logic       ed;
            logic       eb;
            logic [2:0] ep;
            drive((c == 1) || (c == 3) || (c == 5) || (c == 7), 4'd5, 4'd0, 1'b0);
            tick();
            ed = (c <= 27) && (c % 7 != 0);
            eb = (c <= 28);
            if (c < 3)       ep = 3'd0;
            else if (c < 5)  ep = 3'd1;
            else if (c < 7)  ep = 3'd2;
            else if (c == 7) ep = 3'd3;
            else             ep = 3'(3 - 1 - int'(c >= 15) - int'(c >= 22));
            chk("queue", c, 32'(act()), 32'(pk(ed, eb, ep, 1'b0)));
        end

        // nine edges while busy: saturate at 7, ovf set, clear vs set
        for (int c = 1; c <= 20; c++) begin
            drive((c % 2 == 1) && (c <= 19), 4'd15, 4'd15, (c == 18) || (c == 19));
            tick();
            if (c == 15) chk("ovf_pend7", c, 32'({bus.pend_o, bus.ovf_o}), 32'({3'd7, 1'b0}));
            if (c == 17) chk("ovf_sat",   c, 32'({bus.pend_o, bus.ovf_o}), 32'({3'd7, 1'b1}));
            if (c == 18) chk("ovf_clr",   c, 32'(bus.ovf_o), 32'd0);
            if (c == 19) chk("ovf_setwin", c, 32'(bus.ovf_o), 32'd1);
            if (c == 20) chk("ovf_sticky", c, 32'(bus.ovf_o), 32'd1);
        end
`else
        // edge during a pulse is lost and flags ovf; set beats clear
        for (int c = 1; c <= 8; c++) begin
            drive((c == 1) || (c == 3) || (c == 5), 4'd5, 4'd0, (c == 4) || (c == 5));
            tick();
            chk("noq_ovf", c, 32'(act()),
                32'(pk(c <= 6, c <= 7, 3'd0, (c == 3) || (c >= 5))));
        end
`endif

        // asynchronous reset mid-pulse
        do_reset();
        tick();
        chk("reset_clean", 0, 32'(act()), 32'(pk(0, 0, 0, 0)));
        for (int c = 1; c <= 5; c++) begin
            drive(c % 2 == 1, 4'd5, 4'd0, 1'b0);
            tick();
        end
        chk("pre_reset", 0, 32'(act()),
            32'(pk(1, 1, QEN ? 3'd2 : 3'd0, QEN ? 1'b0 : 1'b1)));
        #3;
        reset_ni = 1'b0;
        bus.trig_i = 1'b0;
        #1;
        chk("async_reset", 0, 32'(act()), 32'(pk(0, 0, 0, 0)));
        tick();
        tick();
        reset_ni = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("post_reset", c, 32'(act()), 32'(pk(0, 0, 0, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ste_pulse_gen.md
# ste_pulse_gen

Output pulse generator: the transmit-side counterpart of the input debouncer. Each rising edge on a trigger input produces one clean pulse on dout_o with a programmable high time and a guaranteed minimum low time. Triggers arriving during a pulse are queued. It drives LEDs, buzzers and strobe pins from single-cycle control events in the dice design.

## Interface
- CNT_W, 4: width of the high/low duration counter and duration inputs
- PEND_W, 3: width of the pending-trigger counter (max 2^PEND_W-1 queued)
- clk  input  1  system clock, rising edge
- reset_ni  input  1  asynchronous, active-low reset
- trig_i  input  1  trigger; a 0->1 transition requests one pulse (synchronous to clk)
- len_high_i  input  CNT_W  high time minus one, in clk cycles
- len_low_i  input  CNT_W  minimum low time minus one, in clk cycles
- clr_ovf_i  input  1  synchronous clear of ovf_o
- dout_o  output  1  registered pulse output
- busy_o  output  1  high while state != IDLE
- pend_o  output  PEND_W  number of queued, not yet started pulses
- ovf_o  output  1  sticky: a trigger was lost

## Operation
- Edge detect: trig_q is a register of trig_i; edge = trig_i & ~trig_q. trig_q resets to 0, so trig_i held high through reset release counts as an edge on the first clock.
- start = (pend_o != 0) | edge.
- FSM states: IDLE, HIGH, LOW. The duration counter cnt is CNT_W bits and decrements by 1 per cycle; it never wraps.
- IDLE: dout_o=0. If start: cnt<=len_high_i, dout_o<=1, go HIGH.
- HIGH: if cnt!=0, cnt<=cnt-1. If cnt==0: cnt<=len_low_i, dout_o<=0, go LOW.
- LOW: if cnt!=0, cnt<=cnt-1. If cnt==0 and start: cnt<=len_high_i, dout_o<=1, go HIGH. If cnt==0 and no start: go IDLE.
- len_high_i and len_low_i are sampled only at load. Changes mid-phase have no effect on the current phase.
- Pending counter, applied per cycle:
  - pulse started from the queue (start taken with pend_o!=0): decrement;
  - edge not consumed by a start in the same cycle: increment;
  - edge with a start in the same cycle: the edge is consumed only when pend_o==0 (bypass), otherwise the edge increments and the queue head decrements, for a net change of 0.
- Saturation: an increment at pend_o == 2^PEND_W-1 is dropped, and ovf_o<=1.
- ovf_o: clr_ovf_i clears it. If set and clear occur in the same cycle, set wins.
- busy_o is combinational from the state register.

## Timing
- Reset values: dout_o=0, busy_o=0, pend_o=0, ovf_o=0, state=IDLE, cnt=0, trig_q=0.
- Reset asserted mid-pulse: dout_o goes 0 asynchronously and the queue is discarded.
- Latency: an edge sampled at posedge N in IDLE gives dout_o=1 after posedge N.
- High width: exactly len_high_i+1 cycles.
- Low width between queued pulses: exactly len_low_i+1 cycles. Period = len_high_i+len_low_i+2.
- A trigger arriving while idle with the low time already expired starts after 1 cycle.
- len=0 gives a 1-cycle phase. len = 2^CNT_W-1 gives 2^CNT_W cycles.

## Configuration
- STE_PULSE_GEN_QUEUE_EN defined: pending counter as described.
- Not defined: no counter is built and pend_o is tied to 0.
  - start = edge & (state==IDLE | (state==LOW & cnt==0)).
  - Any edge not accepted as a start sets ovf_o.

## Test plan
- Reset, then trig_i 0->1 with len_high_i=2, len_low_i=1: dout_o high for 3 cycles starting 1 cycle after the edge; busy_o deasserts after 2 low cycles.
- Queue (QUEUE_EN, PEND_W=3): 3 edges during the first pulse (len_high_i=5, len_low_i=0). Expected: pend_o 1,2,3, then 4 pulses each 6 cycles high with 1-cycle gaps; pend_o decrements at each pulse start.
- Overflow: 9 edges while busy with PEND_W=3. Expected: pend_o stops at 7 and ovf_o=1. clr_ovf_i with no edge clears it; clear together with an overflowing edge keeps it at 1.
- len_high_i=0, len_low_i=0, trig_i toggling every cycle: dout_o follows a 1-high/1-low pattern.
- len_high_i changed from 7 to 1 mid-pulse: the current pulse still lasts 8 cycles and the next pulse lasts 2 cycles.
- reset_ni low during HIGH with pend_o=2: dout_o=0 immediately, pend_o=0. After release, no pulse occurs unless a new edge arrives.
